float_to_unsig_int: RTL and testbench

// Multicycle IEEE-754 single -> unsigned 32-bit integer converter. It is the inverse of unsig_int_to_float and

---
 rtl/float_to_unsig_int.sv | 152 +++++++++++++++
 tb/tb_float_to_unsig_int.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/float_to_unsig_int.sv
// Multicycle IEEE-754 single to unsigned 32-bit integer converter (round toward zero,
// RISC-V saturation with NV/NX flags) with stb/ack handshakes on both sides.
module float_to_unsig_int #(
  parameter int          SHIFT_STEP = 1,
  parameter logic [31:0] NAN_RESULT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_nv,
  output logic        output_z_nx,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [1:0] {GET_A, UNPACK, SHIFT, PUT_Z} state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state, state_next;
  logic [31:0] a, a_next;
  logic [31:0] shifter, shifter_next;
  logic [4:0]  rem, rem_next;
  logic        sticky, sticky_next;
  logic [31:0] z_next;
  logic        nv_next, nx_next, stb_next, ack_next;

  logic        sign;
  logic [7:0]  ef;
  logic [22:0] frac;
  logic        normal;
  logic [4:0]  k;
  logic [31:0] out_mask;

  assign sign = a[31];
  assign ef   = a[30:23];
  assign frac = a[22:0];

  // Only positive values in [1.0, 2^32) need the shifter; everything else is decided at unpack.
  assign normal = !sign && (ef >= 8'd127) && (ef <= 8'd158);

  assign k        = (rem < STEP) ? rem : STEP;
  assign out_mask = (32'd1 << k) - 32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= 32'd0;
      output_z_nv  <= 1'b0;
      output_z_nx  <= 1'b0;
      a            <= 32'd0;
      shifter      <= 32'd0;
      rem          <= 5'd0;
      sticky       <= 1'b0;
    end else begin
      state        <= state_next;
      input_a_ack  <= ack_next;
      output_z_stb <= stb_next;
      output_z     <= z_next;
      output_z_nv  <= nv_next;
      output_z_nx  <= nx_next;
      a            <= a_next;
      shifter      <= shifter_next;
      rem          <= rem_next;
      sticky       <= sticky_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      GET_A:   if (input_a_ack && input_a_stb) state_next = UNPACK;
      UNPACK:  state_next = normal ? SHIFT : PUT_Z;
      SHIFT:   if (rem == 5'd0) state_next = PUT_Z;
      PUT_Z:   if (output_z_ack) state_next = GET_A;
      default: state_next = GET_A;
    endcase
  end

  always_comb begin
    a_next       = a;
    shifter_next = shifter;
    rem_next     = rem;
    sticky_next  = sticky;
    z_next       = output_z;
    nv_next      = output_z_nv;
    nx_next      = output_z_nx;
    stb_next     = output_z_stb;
    ack_next     = input_a_ack;
    case (state)
      GET_A: begin
        // ack is re-asserted here so it rises on the first edge after reset
        ack_next = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_next   = input_a;
          ack_next = 1'b0;
        end
      end
      UNPACK: begin
        if (normal) begin
          shifter_next = {1'b1, frac, 8'b0};
          rem_next     = 5'(8'd158 - ef);
          sticky_next  = 1'b0;
        end else begin
          stb_next = 1'b1;
          z_next   = 32'd0;
          nv_next  = 1'b0;
          nx_next  = 1'b0;
          if (ef == 8'hFF) begin
            nv_next = 1'b1;
            if (frac != 23'd0) z_next = NAN_RESULT;
            else               z_next = sign ? 32'd0 : 32'hFFFFFFFF;
          end else if (ef == 8'h00) begin
            nx_next = |frac;
          end else if (ef < 8'd127) begin
            nx_next = 1'b1;
          end else if (sign) begin
            nv_next = 1'b1;
          end else begin
            nv_next = 1'b1;
            z_next  = 32'hFFFFFFFF;
          end
        end
      end
      SHIFT: begin
        if (rem == 5'd0) begin
          z_next   = shifter;
          nx_next  = sticky;
          nv_next  = 1'b0;
          stb_next = 1'b1;
        end else begin
          shifter_next = shifter >> k;
          sticky_next  = sticky | (|(shifter & out_mask));
          rem_next     = rem - k;
        end
      end
      PUT_Z: begin
        if (output_z_ack) begin
          stb_next = 1'b0;
          ack_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_float_to_unsig_int.sv
// Directed bench for float_to_unsig_int: a SHIFT_STEP=1 instance and a SHIFT_STEP=8 instance
// checked against hand-computed results, flags and latencies.
module tb_float_to_unsig_int;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a_in  [2];
  logic        a_stb [2];
  logic        a_ack [2];
  logic [31:0] z_out [2];
  logic        nv_out[2];
  logic        nx_out[2];
  logic        z_stb [2];
  logic        z_ack [2];

  float_to_unsig_int #(.SHIFT_STEP(1), .NAN_RESULT(32'hFFFFFFFF)) dut (
    .clk(clk), .rst(rst),
    .input_a(a_in[0]), .input_a_stb(a_stb[0]), .input_a_ack(a_ack[0]),
    .output_z(z_out[0]), .output_z_nv(nv_out[0]), .output_z_nx(nx_out[0]),
    .output_z_stb(z_stb[0]), .output_z_ack(z_ack[0])
  );

  float_to_unsig_int #(.SHIFT_STEP(8), .NAN_RESULT(32'hFFFFFFFF)) dut8 (
    .clk(clk), .rst(rst),
    .input_a(a_in[1]), .input_a_stb(a_stb[1]), .input_a_ack(a_ack[1]),
    .output_z(z_out[1]), .output_z_nv(nv_out[1]), .output_z_nx(nx_out[1]),
    .output_z_stb(z_stb[1]), .output_z_ack(z_ack[1])
  );

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] z;
    logic        nv;
    logic        nx;
    int          lat;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the handshake edge N.
  task automatic startConversion(input int idx, input logic [31:0] val);
    int n = 0;
    while (a_ack[idx] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (a_ack[idx] !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout: input_a_ack got %b, expected 1", a_ack[idx]);
    end
    a_in[idx]  = val;
    a_stb[idx] = 1'b1;
    @(posedge clk); #1;
    a_stb[idx] = 1'b0;
  endtask

  task automatic waitResult(input int idx, output int lat);
    lat = 0;
    while (z_stb[idx] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    startConversion(v.idx, v.a);
    checkOutput({tag, " ack_low"}, 32'(a_ack[v.idx]), 32'd0);
    waitResult(v.idx, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.lat));
    checkOutput({tag, " z"}, z_out[v.idx], v.z);
    checkOutput({tag, " nv"}, 32'(nv_out[v.idx]), 32'(v.nv));
    checkOutput({tag, " nx"}, 32'(nx_out[v.idx]), 32'(v.nx));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   lat;

    vecs.push_back('{0, 32'h40000000, 32'h00000002, 1'b0, 1'b0, 32});
    vecs.push_back('{0, 32'h4F7FF000, 32'hFFF00000, 1'b0, 1'b0, 2});
    vecs.push_back('{0, 32'h3FC00000, 32'h00000001, 1'b0, 1'b1, 33});
    vecs.push_back('{0, 32'hBF000000, 32'h00000000, 1'b0, 1'b1, 1});
    vecs.push_back('{0, 32'hBF800000, 32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{0, 32'h7FC00000, 32'hFFFFFFFF, 1'b1, 1'b0, 1});
    vecs.push_back('{0, 32'hFF800000, 32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{0, 32'h4F800000, 32'hFFFFFFFF, 1'b1, 1'b0, 1});
    vecs.push_back('{0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1});
    vecs.push_back('{0, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1});
    vecs.push_back('{0, 32'h7F800000, 32'hFFFFFFFF, 1'b1, 1'b0, 1});
    vecs.push_back('{0, 32'hFFC00001, 32'hFFFFFFFF, 1'b1, 1'b0, 1});
    vecs.push_back('{0, 32'h3F800000, 32'h00000001, 1'b0, 1'b0, 33});
    vecs.push_back('{0, 32'h4B000001, 32'h00800001, 1'b0, 1'b0, 10});
    vecs.push_back('{0, 32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b1, 33});
    vecs.push_back('{0, 32'h4F7FFFFF, 32'hFFFFFF00, 1'b0, 1'b0, 2});
    vecs.push_back('{0, 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 3});
    vecs.push_back('{0, 32'hCF000000, 32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{0, 32'h3F7FFFFF, 32'h00000000, 1'b0, 1'b1, 1});
    vecs.push_back('{0, 32'h40490FDB, 32'h00000003, 1'b0, 1'b1, 32});
    vecs.push_back('{1, 32'h40000000, 32'h00000002, 1'b0, 1'b0, 6});
    vecs.push_back('{1, 32'h3FC00000, 32'h00000001, 1'b0, 1'b1, 6});
    vecs.push_back('{1, 32'h4F7FF000, 32'hFFF00000, 1'b0, 1'b0, 2});
    vecs.push_back('{1, 32'h41200000, 32'h0000000A, 1'b0, 1'b0, 6});
    vecs.push_back('{1, 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 3});

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_in[i]  = 32'd0;
      a_stb[i] = 1'b0;
      z_ack[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset stb", 32'(z_stb[0]), 32'd0);
    checkOutput("reset ack", 32'(a_ack[0]), 32'd0);
    checkOutput("reset z", z_out[0], 32'd0);
    checkOutput("reset nv", 32'(nv_out[0]), 32'd0);
    checkOutput("reset nx", 32'(nx_out[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("ack after reset", 32'(a_ack[0]), 32'd1);
    checkOutput("ack after reset step8", 32'(a_ack[1]), 32'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], $sformatf("vec%0d a=%h", i, vecs[i].a));
      checkOutput($sformatf("vec%0d nv_nx_exclusive", i),
                  32'(nv_out[vecs[i].idx] & nx_out[vecs[i].idx]), 32'd0);
    end

    // Backpressure: result held while the consumer stalls
    @(posedge clk); #1;
    z_ack[0] = 1'b0;
    startConversion(0, 32'h40000000);
    waitResult(0, lat);
    checkOutput("bp latency", 32'(lat), 32'd32);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d z", c), z_out[0], 32'd2);
      checkOutput($sformatf("bp%0d stb", c), 32'(z_stb[0]), 32'd1);
      checkOutput($sformatf("bp%0d in_ack", c), 32'(a_ack[0]), 32'd0);
      checkOutput($sformatf("bp%0d flags", c), 32'({nv_out[0], nx_out[0]}), 32'd0);
    end
    z_ack[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release stb", 32'(z_stb[0]), 32'd0);
    checkOutput("bp release in_ack", 32'(a_ack[0]), 32'd1);

    // Reset in the middle of a shift aborts the conversion
    startConversion(0, 32'h40000000);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset stb", 32'(z_stb[0]), 32'd0);
    checkOutput("midreset ack", 32'(a_ack[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset ack rise", 32'(a_ack[0]), 32'd1);
    checkOutput("midreset no result", 32'(z_stb[0]), 32'd0);
    applyStimulus('{0, 32'h41200000, 32'h0000000A, 1'b0, 1'b0, 30}, "after reset 10.0");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
